// File: rtl/key_step_generator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_step_pkg                                                    |
// | Purpose  : Shared types and constants for the key step generator.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package key_step_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } step_state_t;

  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 0;

  typedef logic [3:0] key_vec_t;

  // True when exactly one key is held (popcount == 1).
  function automatic logic is_one_hot(input key_vec_t v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_step_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_step_generator_if                                           |
// | Purpose  : Button inputs and step/level outputs of the key step generator. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface key_step_generator_if;
  import key_step_pkg::*;

  key_vec_t key_raw;   // raw asynchronous buttons
  key_vec_t key;       // one-cycle step strobe
  key_vec_t key_held;  // debounced pressed level

  // Board / stimulus side: drives buttons, observes steps.
  modport master (output key_raw, input key, input key_held);
  // Generator side.
  modport slave  (input key_raw, output key, output key_held);
endinterface
`default_nettype wire

// File: rtl/key_step_generator_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_debounce                                                    |
// | Purpose  : One button: 2-flop synchroniser, polarity normalisation and a   |
// |            stable-count debouncer producing an active-high held level.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_raw,
  output logic      o_held
);

  localparam int              CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   C_TERM = CW'(DEBOUNCE_CYCLES - 1);
  // Raw level of a released button; sync flops reset to it so reset reads "released".
  localparam logic            C_RELEASED = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_held;
  logic [CW-1:0] r_cnt;
  logic          w_level;

  assign w_level = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign o_held  = r_held;

  // Synchronise, then accept a level change only after it stays stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= C_RELEASED;
      r_sync2 <= C_RELEASED;
      r_held  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (w_level != r_held) begin
        if (r_cnt == C_TERM) begin
          r_held <= ~r_held;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_step_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_step_generator                                              |
// | Purpose  : Debounces four direction buttons and emits one-hot, one-cycle   |
// |            step strobes, with optional hold-to-auto-repeat.                |
// | Config   : KEY_AUTO_REPEAT_EN - defined: DELAY/REPEAT auto-repeat;         |
// |            undefined: one strobe per debounced press.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_step_generator
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 12_500_000,
  parameter int REPEAT_PERIOD   = 1_250_000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input wire logic clk,
  input wire logic rst,
  key_step_generator_if.slave bus
);

  key_vec_t w_held;
  logic     w_valid;
  key_vec_t r_key;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (bus.key_raw[i]),
      .o_held (w_held[i])
    );
  end

  assign w_valid      = is_one_hot(w_held);
  assign bus.key_held = w_held;
  assign bus.key      = r_key;

`ifdef KEY_AUTO_REPEAT_EN

  localparam int            RPT_MAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            CW            = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [CW-1:0] C_DELAY_TERM  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] C_PERIOD_TERM = CW'(REPEAT_PERIOD - 1);

  step_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  key_vec_t      r_dir,   w_dir_nxt;
  key_vec_t      w_key_nxt;

  // State register plus registered strobe, direction and repeat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_key   <= w_key_nxt;
    end
  end

  // Next state: invalid selection always returns to IDLE; a new single key restarts DELAY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_valid) w_state_nxt = DELAY;
      end
      DELAY: begin
        if (!w_valid)                  w_state_nxt = IDLE;
        else if (w_held != r_dir)      w_state_nxt = DELAY;
        else if (r_cnt == C_DELAY_TERM) w_state_nxt = REPEAT;
      end
      REPEAT: begin
        if (!w_valid)             w_state_nxt = IDLE;
        else if (w_held != r_dir) w_state_nxt = DELAY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobe, direction latch and counter reload on each terminal count or fresh press.
  always_comb begin
    w_key_nxt = '0;
    w_dir_nxt = r_dir;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_key_nxt = w_held;
          w_dir_nxt = w_held;
          w_cnt_nxt = '0;
        end
      end
      DELAY, REPEAT: begin
        if (!w_valid) begin
          w_cnt_nxt = '0;
        end else if (w_held != r_dir) begin
          w_key_nxt = w_held;
          w_dir_nxt = w_held;
          w_cnt_nxt = '0;
        end else if (r_cnt == ((r_state == DELAY) ? C_DELAY_TERM : C_PERIOD_TERM)) begin
          w_key_nxt = r_dir;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

`else

  // Without auto-repeat the only state is the key already stepped for the
  // current press (zero = IDLE); a strobe fires when a valid key differs from it.
  key_vec_t r_dir, w_dir_nxt;
  key_vec_t w_key_nxt;

  // State register plus registered strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir <= '0;
      r_key <= '0;
    end else begin
      r_dir <= w_dir_nxt;
      r_key <= w_key_nxt;
    end
  end

  // Next state: follow the held key while valid, fall back to IDLE otherwise.
  always_comb begin
    w_dir_nxt = w_valid ? w_held : '0;
  end

  // One strobe on entering a new single-key selection.
  always_comb begin
    w_key_nxt = '0;
    if (w_valid && (w_held != r_dir)) w_key_nxt = w_held;
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_key_step_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_key_step_generator                                           |
// | Purpose  : Directed, self-checking bench for key_step_generator.           |
// | Config   : expectations follow KEY_AUTO_REPEAT_EN when it is defined.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_key_step_generator;
  import key_step_pkg::*;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_step_generator_if kif ();

  key_step_generator #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  typedef struct {
    logic [3:0] raw;
    int         n;
    logic [3:0] held;
    int         cnt_auto;
    int         cnt_man;
    logic [3:0] last;
  } vec_t;

  int       total = 0;
  int       bad   = 0;
  int       cyc   = 0;
  int       strobe_cyc[$];
  key_vec_t strobe_val[$];
  key_vec_t prev_key = '0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock; observe at the falling edge and enforce strobe shape every cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst) begin
      total++;
      if (($countones(kif.key) > 1) || ((prev_key != 0) && (kif.key != 0))) begin
        bad++;
        $display("FAIL strobe_shape: key=%b prev=%b (cycle %0d)", kif.key, prev_key, cyc);
      end
      if (kif.key != 0) begin
        strobe_cyc.push_back(cyc);
        strobe_val.push_back(kif.key);
      end
    end
    prev_key = kif.key;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  vec_t tbl[11];
  int   n0, n1, c0, exp_n, got_n;
  int   exp_t[$];

  initial begin
    tbl[0]  = '{4'b1110,  3, 4'b0000, 0, 0, 4'b0000};
    tbl[1]  = '{4'b1111, 10, 4'b0000, 0, 0, 4'b0000};
    tbl[2]  = '{4'b1110,  2, 4'b0000, 0, 0, 4'b0000};
    tbl[3]  = '{4'b1111,  1, 4'b0000, 0, 0, 4'b0000};
    tbl[4]  = '{4'b1110,  2, 4'b0000, 0, 0, 4'b0000};
    tbl[5]  = '{4'b1111, 10, 4'b0000, 0, 0, 4'b0000};
    tbl[6]  = '{4'b1101,  8, 4'b0010, 1, 1, 4'b0010};
    tbl[7]  = '{4'b1111, 12, 4'b0000, 0, 0, 4'b0000};
    tbl[8]  = '{4'b0111,  9, 4'b1000, 1, 1, 4'b1000};
    tbl[9]  = '{4'b1011, 10, 4'b0100, 1, 1, 4'b0100};
    tbl[10] = '{4'b1111, 12, 4'b0000, 0, 0, 4'b0000};

    // Reset and idle.
    rst = 1'b1;
    kif.key_raw = 4'b1111;
    ticks(3);
    check("reset_key", kif.key, 0);
    check("reset_held", kif.key_held, 0);
    rst = 1'b0;
    n0 = strobe_cyc.size();
    ticks(20);
    check("idle_strobes", strobe_cyc.size() - n0, 0);

    // Single short press of up: level after DB+2 edges, strobe one edge later.
    n0 = strobe_cyc.size();
    kif.key_raw = 4'b0111;
    ticks(5);
    check("up_held_early", kif.key_held, 4'b0000);
    tick();
    check("up_held_rise", kif.key_held, 4'b1000);
    kif.key_raw = 4'b1111;
    tick();
    check("up_strobe", kif.key, 4'b1000);
    ticks(20);
    check("up_strobe_count", strobe_cyc.size() - n0, 1);
    check("up_held_released", kif.key_held, 4'b0000);

    // Table: glitches, bounce, single press, direct key-to-key switch.
    for (int i = 0; i < 11; i++) begin
      kif.key_raw = tbl[i].raw;
      n0 = strobe_cyc.size();
      ticks(tbl[i].n);
      exp_n = AUTO ? tbl[i].cnt_auto : tbl[i].cnt_man;
      check($sformatf("tbl%0d_held", i), kif.key_held, tbl[i].held);
      check($sformatf("tbl%0d_count", i), strobe_cyc.size() - n0, exp_n);
      if ((exp_n > 0) && (strobe_val.size() > 0))
        check($sformatf("tbl%0d_last", i), strobe_val[$], tbl[i].last);
    end

    // Long hold of left: auto-repeat schedule while held level is valid (edges 7..46).
    n0 = strobe_cyc.size();
    c0 = cyc;
    kif.key_raw = 4'b1101;
    ticks(40);
    kif.key_raw = 4'b1111;
    ticks(20);
    exp_t.delete();
    exp_t.push_back(7);
    if (AUTO) for (int e = 17; e <= 46; e += RP) exp_t.push_back(e);
    got_n = strobe_cyc.size() - n0;
    check("hold_count", got_n, exp_t.size());
    for (int i = 0; i < exp_t.size() && i < got_n; i++) begin
      check($sformatf("hold_time%0d", i), strobe_cyc[n0 + i] - c0, exp_t[i]);
      check($sformatf("hold_val%0d", i), strobe_val[n0 + i], 4'b0010);
    end

    // Down, then down+up (invalid), then back to down alone: fresh strobe, timing restarts.
    n0 = strobe_cyc.size();
    kif.key_raw = 4'b1011;
    ticks(7);
    check("two_first_strobe", kif.key, 4'b0100);
    tick();
    kif.key_raw = 4'b0011;
    ticks(12);
    check("two_held_both", kif.key_held, 4'b1100);
    check("two_no_strobe", strobe_cyc.size() - n0, 1);
    kif.key_raw = 4'b1011;
    ticks(6);
    check("two_held_down", kif.key_held, 4'b0100);
    check("two_pre_strobe", kif.key, 4'b0000);
    tick();
    check("two_fresh_strobe", kif.key, 4'b0100);
    n1 = strobe_cyc.size();
    ticks(9);
    check("two_gap", strobe_cyc.size() - n1, 0);
    tick();
    check("two_repeat", kif.key, AUTO ? 4'b0100 : 4'b0000);
    kif.key_raw = 4'b1111;
    ticks(15);

    // Reset while right is held: press must re-debounce; first strobe DB+3 edges after.
    kif.key_raw = 4'b1110;
    ticks(22);
    rst = 1'b1;
    tick();
    check("rst_mid_key", kif.key, 0);
    check("rst_mid_held", kif.key_held, 0);
    rst = 1'b0;
    n0 = strobe_cyc.size();
    ticks(DB + 2);
    check("rst_rehold", kif.key_held, 4'b0001);
    check("rst_no_early", strobe_cyc.size() - n0, 0);
    tick();
    check("rst_first_strobe", kif.key, 4'b0001);
    kif.key_raw = 4'b1111;
    ticks(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
